// File: rtl/uart_tx_pkg.sv
// Shared state encoding and line levels for the UART transmit frame sequencer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register plus bit counter for the data portion of a frame.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  tx_bit,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (load) begin
      shift_reg <= data;
      cnt       <= '0;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      cnt       <= cnt + CW'(1);
    end
  end

  // Look-ahead bit: the line is registered, so while shifting the next bit is presented.
  assign tx_bit = shift_en ? shift_reg[1] : shift_reg[0];
  assign done   = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop.
// Build option UART_TX_TWO_STOP_EN stretches STOP to two bit times.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  tx_state_t state, nxt;
  logic      par_en_q;
  logic      accept, stop_last;
  logic      ser_bit, ser_done;
  logic      tx_nxt, fd_nxt;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stop_q <= 1'b0;
    else      stop_q <= (state == STOP) && !stop_q;
  end
  assign stop_last = stop_q;
`else
  assign stop_last = 1'b1;
`endif

  assign accept = data_valid && ((state == IDLE) || ((state == STOP) && stop_last));

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift_en (state == DATA),
    .data     (P_Data),
    .tx_bit   (ser_bit),
    .done     (ser_done)
  );

  always_comb begin
    nxt    = state;
    tx_nxt = IDLE_LEVEL;
    fd_nxt = 1'b0;
    case (state)
      IDLE:    if (accept) nxt = START;
      START:   nxt = DATA;
      DATA:    if (ser_done) nxt = par_en_q ? PARITY : STOP;
      PARITY:  nxt = STOP;
      STOP:    if (stop_last) nxt = accept ? START : IDLE;
      default: nxt = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state register.
    case (nxt)
      START:   tx_nxt = START_BIT;
      DATA:    tx_nxt = ser_bit;
      PARITY:  tx_nxt = par_bit;
      STOP:    tx_nxt = STOP_BIT;
      default: tx_nxt = IDLE_LEVEL;
    endcase
`ifdef UART_TX_TWO_STOP_EN
    fd_nxt = (nxt == STOP) && (state == STOP);
`else
    fd_nxt = (nxt == STOP);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      TX_OUT     <= IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      par_en_q   <= 1'b0;
    end else begin
      state      <= nxt;
      TX_OUT     <= tx_nxt;
      busy       <= (nxt != IDLE);
      frame_done <= fd_nxt;
      if (accept) par_en_q <= par_en;
    end
  end

endmodule
